// File: rtl/bcd_counter_n.sv
// bcd_counter_n - parametrised multi-digit BCD up/down counter.
//
// Decimal counting core for timers, event tallies and display drivers.
// Stages chain by feeding one stage's cout into the next stage's en.
// All stages share clk, clr and up.
//
// Parameters:
//   DIGITS  number of BCD digits (1..8); range 0 .. 10^DIGITS-1
//
// Ports:
//   clk   rising-edge clock
//   clr   synchronous active-high clear (q <= 0, ovf <= 0); highest priority
//   load  synchronous parallel load of data; non-BCD digits are clamped to 9
//   en    count enable, also the cascade carry-in
//   up    direction: 1 = count up, 0 = count down
//   data  BCD load value, digit 0 in data[3:0]
//   q     BCD count value, digit 0 in q[3:0]
//   cout  combinational terminal-count / cascade carry
//   ovf   registered sticky flag, set on wrap (or saturation event)
//
// Build option:
//   BCD_CNT_SAT_EN  when defined, the counter saturates at all-9s (up) or
//                   all-0s (down) instead of wrapping.
module bcd_counter_n #(
  parameter int unsigned DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  load,
  input  logic                  en,
  input  logic                  up,
  input  logic [4*DIGITS-1:0]   data,
  output logic [4*DIGITS-1:0]   q,
  output logic                  cout,
  output logic                  ovf
);

  logic [4*DIGITS-1:0] q_step;
  logic [4*DIGITS-1:0] q_next;
  logic [4*DIGITS-1:0] q_load;
  logic                all9;
  logic                all0;
  logic                term;
  logic                ripple;
  logic [3:0]          digit;
  logic [3:0]          nd;

  // Terminal detection: all digits at 9 (counting up) or 0 (counting down).
  always_comb begin
    all9 = 1'b1;
    all0 = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (q[4*i +: 4] != 4'd9) all9 = 1'b0;
      if (q[4*i +: 4] != 4'd0) all0 = 1'b0;
    end
  end

  assign term = up ? all9 : all0;
  assign cout = en & ~clr & ~load & term;

  // Ripple carry/borrow across digits; a digit steps only while every
  // lower digit is at its terminal value.
  always_comb begin
    q_step = '0;
    ripple = 1'b1;
    digit  = '0;
    nd     = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      digit = q[4*i +: 4];
      nd    = digit;
      if (ripple) begin
        if (up) begin
          if (digit == 4'd9) begin
            nd = 4'd0;
          end else begin
            nd     = digit + 4'd1;
            ripple = 1'b0;
          end
        end else begin
          if (digit == 4'd0) begin
            nd = 4'd9;
          end else begin
            nd     = digit - 4'd1;
            ripple = 1'b0;
          end
        end
      end
      q_step[4*i +: 4] = nd;
    end
  end

`ifdef BCD_CNT_SAT_EN
  assign q_next = term ? q : q_step;
`else
  assign q_next = q_step;
`endif

  always_comb begin
    q_load = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      q_load[4*i +: 4] = (data[4*i +: 4] > 4'd9) ? 4'd9 : data[4*i +: 4];
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      q   <= '0;
      ovf <= 1'b0;
    end else if (load) begin
      q   <= q_load;
      ovf <= 1'b0;
    end else if (en) begin
      q <= q_next;
      if (term) ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bcd_counter_n.sv
// tb_bcd_counter_n - directed, table-driven bench for bcd_counter_n (DIGITS=2).
// Each vector: inputs are driven after the falling edge, cout is checked
// before the rising edge, then q and ovf are checked just after it.
// Builds with or without BCD_CNT_SAT_EN; expectations follow the build.
module tb_bcd_counter_n;

  logic       clk;
  logic       clr;
  logic       load;
  logic       en;
  logic       up;
  logic [7:0] data;
  logic [7:0] q;
  logic       cout;
  logic       ovf;

  int checks;
  int errors;

  bcd_counter_n #(.DIGITS(2)) dut (
    .clk  (clk),
    .clr  (clr),
    .load (load),
    .en   (en),
    .up   (up),
    .data (data),
    .q    (q),
    .cout (cout),
    .ovf  (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       clr;
    logic       load;
    logic       en;
    logic       up;
    logic [7:0] data;
    logic       exp_cout;
    logic [7:0] exp_q;
    logic       exp_ovf;
  } vec_t;

  localparam int NV = 27;
  vec_t vecs[NV];

  function automatic vec_t mk(input logic c, input logic l, input logic e,
                              input logic u, input logic [7:0] d,
                              input logic ec, input logic [7:0] eq,
                              input logic eo);
    vec_t v;
    v.clr = c; v.load = l; v.en = e; v.up = u; v.data = d;
    v.exp_cout = ec; v.exp_q = eq; v.exp_ovf = eo;
    return v;
  endfunction

  task automatic check8(input string name, input int idx,
                        input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic check1(input string name, input int idx,
                        input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %b expected %b", name, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    clr  = v.clr;
    load = v.load;
    en   = v.en;
    up   = v.up;
    data = v.data;
    #1;
    check1("cout", idx, cout, v.exp_cout);
    @(posedge clk);
    #1;
    check8("q", idx, q, v.exp_q);
    check1("ovf", idx, ovf, v.exp_ovf);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clr = 1'b0; load = 1'b0; en = 1'b0; up = 1'b1; data = 8'h00;

    //               clr  ld   en   up   data    cout q      ovf
    vecs[0]  = mk(1'b1,1'b1,1'b1,1'b1,8'h37, 1'b0,8'h00, 1'b0);
    vecs[1]  = mk(1'b1,1'b1,1'b1,1'b1,8'h37, 1'b0,8'h00, 1'b0);
    vecs[2]  = mk(1'b0,1'b1,1'b1,1'b1,8'h47, 1'b0,8'h47, 1'b0);
    vecs[3]  = mk(1'b0,1'b1,1'b0,1'b1,8'hA5, 1'b0,8'h95, 1'b0);
    vecs[4]  = mk(1'b0,1'b1,1'b0,1'b1,8'h3F, 1'b0,8'h39, 1'b0);
    vecs[5]  = mk(1'b0,1'b0,1'b1,1'b1,8'h00, 1'b0,8'h40, 1'b0);
    vecs[6]  = mk(1'b0,1'b0,1'b1,1'b0,8'h00, 1'b0,8'h39, 1'b0);
    vecs[7]  = mk(1'b0,1'b1,1'b0,1'b1,8'h98, 1'b0,8'h98, 1'b0);
    vecs[8]  = mk(1'b0,1'b0,1'b1,1'b1,8'h00, 1'b0,8'h99, 1'b0);
    vecs[9]  = mk(1'b0,1'b1,1'b1,1'b1,8'h12, 1'b0,8'h12, 1'b0);
    vecs[10] = mk(1'b0,1'b1,1'b0,1'b1,8'h99, 1'b0,8'h99, 1'b0);
`ifdef BCD_CNT_SAT_EN
    vecs[11] = mk(1'b0,1'b0,1'b1,1'b1,8'h00, 1'b1,8'h99, 1'b1);
    vecs[12] = mk(1'b0,1'b0,1'b1,1'b1,8'h00, 1'b1,8'h99, 1'b1);
    vecs[13] = mk(1'b0,1'b0,1'b1,1'b1,8'h00, 1'b1,8'h99, 1'b1);
    for (int i = 14; i <= 18; i++)
      vecs[i] = mk(1'b0,1'b0,1'b0,1'b1,8'h00, 1'b0,8'h99, 1'b1);
`else
    vecs[11] = mk(1'b0,1'b0,1'b1,1'b1,8'h00, 1'b1,8'h00, 1'b1);
    vecs[12] = mk(1'b0,1'b0,1'b1,1'b1,8'h00, 1'b0,8'h01, 1'b1);
    vecs[13] = mk(1'b0,1'b0,1'b1,1'b1,8'h00, 1'b0,8'h02, 1'b1);
    for (int i = 14; i <= 18; i++)
      vecs[i] = mk(1'b0,1'b0,1'b0,1'b1,8'h00, 1'b0,8'h02, 1'b1);
`endif
    vecs[19] = mk(1'b0,1'b1,1'b0,1'b1,8'h10, 1'b0,8'h10, 1'b0);
    vecs[20] = mk(1'b0,1'b0,1'b1,1'b0,8'h00, 1'b0,8'h09, 1'b0);
    vecs[21] = mk(1'b0,1'b1,1'b0,1'b0,8'h00, 1'b0,8'h00, 1'b0);
`ifdef BCD_CNT_SAT_EN
    vecs[22] = mk(1'b0,1'b0,1'b1,1'b0,8'h00, 1'b1,8'h00, 1'b1);
    vecs[23] = mk(1'b0,1'b0,1'b1,1'b0,8'h00, 1'b1,8'h00, 1'b1);
    vecs[24] = mk(1'b0,1'b0,1'b1,1'b1,8'h00, 1'b0,8'h01, 1'b1);
`else
    vecs[22] = mk(1'b0,1'b0,1'b1,1'b0,8'h00, 1'b1,8'h99, 1'b1);
    vecs[23] = mk(1'b0,1'b0,1'b1,1'b0,8'h00, 1'b0,8'h98, 1'b1);
    vecs[24] = mk(1'b0,1'b0,1'b1,1'b1,8'h00, 1'b0,8'h99, 1'b1);
`endif
    vecs[25] = mk(1'b1,1'b1,1'b1,1'b1,8'h55, 1'b0,8'h00, 1'b0);
    vecs[26] = mk(1'b1,1'b0,1'b1,1'b0,8'h00, 1'b0,8'h00, 1'b0);

    for (int i = 0; i < NV; i++) apply(vecs[i], i);

    // Full up-count sweep from zero, past the terminal value.
    @(negedge clk);
    clr = 1'b1; load = 1'b0; en = 1'b0; up = 1'b1;
    @(negedge clk);
    clr = 1'b0; en = 1'b1; up = 1'b1;
    for (int i = 1; i <= 120; i++) begin
      int v;
      logic [7:0] eq;
      @(posedge clk);
      #1;
`ifdef BCD_CNT_SAT_EN
      v = (i > 99) ? 99 : i;
`else
      v = i % 100;
`endif
      eq = 8'((v / 10) * 16 + (v % 10));
      check8("sweep_q", i, q, eq);
      check1("sweep_ovf", i, ovf, (i >= 100) ? 1'b1 : 1'b0);
    end

    @(negedge clk);
    en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
